// File: rtl/arb_pkg.sv
// Shared constants for the 4-way round-robin packet arbiter: FSM encodings,
// requester count, select width and the beat-counter width helper.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;

    // Counter must be able to hold the value MAX_BEATS itself.
    function automatic int beat_cnt_w(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/mux41.sv
// Plain 4:1 multiplexer of W-bit words.
module mux41 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] a2,
    input  logic [W-1:0] a3,
    input  logic [1:0]   sel,
    output logic [W-1:0] y
);

    always_comb begin
        case (sel)
            2'd0:    y = a0;
            2'd1:    y = a1;
            2'd2:    y = a2;
            default: y = a3;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Round-robin picker: first asserted request scanning ptr, ptr+1, ... (mod 4).
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   pick
);

    logic [SEL_W-1:0] idx;

    // NOTE: every output of a combinational block gets a default first,
    // otherwise paths that skip an assignment infer a latch.
    always_comb begin
        any  = 1'b0;
        pick = ptr;
        idx  = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (!any && req[idx]) begin
                any  = 1'b1;
                pick = idx;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter sharing one datapath among 4 packet requesters; the grant
// is held for a whole packet (or MAX_BEATS beats) and steers a 4:1 data mux.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   d1,
    input  logic [WIDTH-1:0]   d2,
    input  logic [WIDTH-1:0]   d3,
    input  logic [WIDTH-1:0]   d4,
    input  logic [NUM_REQ-1:0] in_valid,
    input  logic [NUM_REQ-1:0] in_last,
    output logic [NUM_REQ-1:0] in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   sel,
    output logic               busy
);

    localparam int CNT_W = beat_cnt_w(MAX_BEATS);
    localparam logic [CNT_W-1:0] BEAT_MAX = CNT_W'(MAX_BEATS);

    logic [1:0]       state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] beat_next;
    logic             any;
    logic [SEL_W-1:0] pick;
    logic             xfer;
    logic             release_grant;

    rr_pick4 u_pick (
        .req  (in_valid),
        .ptr  (ptr),
        .any  (any),
        .pick (pick)
    );

    mux41 #(.W(WIDTH + 1)) u_mux (
        .a0  ({in_last[0], d1}),
        .a1  ({in_last[1], d2}),
        .a2  ({in_last[2], d3}),
        .a3  ({in_last[3], d4}),
        .sel (sel),
        .y   ({out_last, out_data})
    );

    assign busy      = (state == ST_BUSY);
    assign out_valid = busy & in_valid[sel];
    assign xfer      = out_valid & out_ready;

    always_comb begin
        in_ready = '0;
        if (busy)
            in_ready[sel] = out_ready;
    end

    assign beat_next     = (beat_cnt == BEAT_MAX) ? beat_cnt : beat_cnt + 1'b1;
    assign release_grant = xfer & (out_last | (beat_next == BEAT_MAX));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sel      <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        sel      <= pick;
                        state    <= ST_BUSY;
                        beat_cnt <= '0;
                    end
                end
                ST_BUSY: begin
                    if (xfer)
                        beat_cnt <= beat_next;
                    if (release_grant) begin
                        state <= ST_IDLE;
                        ptr   <= sel + SEL_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed testbench for rr_arbiter4 (MAX_BEATS=4) with hand-computed expectations.
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d [4];
    logic [3:0] in_valid;
    logic [3:0] in_last;
    logic [3:0] in_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] sel;
    logic       busy;

    int errors = 0;
    int checks = 0;

    rr_arbiter4 #(.WIDTH(8), .MAX_BEATS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d1        (d[0]),
        .d2        (d[1]),
        .d3        (d[2]),
        .d4        (d[3]),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Inputs change at the falling edge; outputs are sampled 1ns later.
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 4'hF; in_last = 4'h0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = 8'h00;
        @(posedge clk); @(posedge clk); @(negedge clk); #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", sel); end
    endtask

    // All four channels send 2-beat packets: each packet is IDLE + 2 transfers.
    task automatic test_all_four();
        int p, ph;
        logic [3:0] exp_rdy;
        logic [7:0] exp_data;
        rst_n = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            p  = c / 3;
            ph = c % 3;
            exp_data   = 8'(8'h10 * (p + 1) + ((ph == 2) ? 1 : 0));
            d[p]       = exp_data;
            in_last[p] = (ph == 2);
            exp_rdy    = (ph == 0) ? 4'b0000 : 4'(1 << p);
            #1;
            checks++; if (busy !== (ph != 0)) begin errors++; $display("FAIL rr4_busy c%0d: got %b expected %b", c, busy, ph != 0); end
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rr4_in_ready c%0d: got %b expected %b", c, in_ready, exp_rdy); end
            if (ph != 0) begin
                checks++; if (sel !== 2'(p)) begin errors++; $display("FAIL rr4_sel c%0d: got %0d expected %0d", c, sel, p); end
                checks++; if (out_data !== exp_data) begin errors++; $display("FAIL rr4_data c%0d: got %h expected %h", c, out_data, exp_data); end
                checks++; if (out_last !== (ph == 2)) begin errors++; $display("FAIL rr4_last c%0d: got %b expected %b", c, out_last, ph == 2); end
            end
            next_cycle();
        end
        in_last = 4'h0;
    endtask

    // ptr=0 with only ch2 requesting, then ch0+ch2 with ptr=3 (wrap to ch0).
    task automatic test_wrap();
        in_valid = 4'b0100; in_last = 4'b0100; d[2] = 8'h2A;
        next_cycle(); #1;
        checks++; if (sel !== 2'd2) begin errors++; $display("FAIL wrap_pick2_sel: got %0d expected 2", sel); end
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL wrap_pick2_rdy: got %b expected 0100", in_ready); end
        checks++; if (out_data !== 8'h2A) begin errors++; $display("FAIL wrap_pick2_data: got %h expected 2a", out_data); end
        next_cycle();
        in_valid = 4'b0101; in_last = 4'b0101; d[0] = 8'h0B; d[2] = 8'h2B; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_idle: got %b expected 0", busy); end
        next_cycle(); #1;
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL wrap_ch0_sel: got %0d expected 0", sel); end
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL wrap_ch0_rdy: got %b expected 0001", in_ready); end
        checks++; if (out_data !== 8'h0B) begin errors++; $display("FAIL wrap_ch0_data: got %h expected 0b", out_data); end
        next_cycle();
        in_valid = 4'b0000; in_last = 4'b0000;
    endtask

    // ch1 3-beat packet under out_ready pattern 1,0,1,0,1 (ptr=1 on entry).
    task automatic test_backpressure();
        int b = 0;
        logic rdy;
        in_valid = 4'b0010; d[1] = 8'hA0; in_last = 4'b0000; out_ready = 1'b1;
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            rdy = (k % 2 == 0);
            out_ready  = rdy;
            d[1]       = 8'(8'hA0 + b);
            in_last[1] = (b == 2);
            #1;
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy k%0d: got %b expected 1", k, busy); end
            checks++; if (out_data !== 8'(8'hA0 + b)) begin errors++; $display("FAIL bp_data k%0d: got %h expected %h", k, out_data, 8'(8'hA0 + b)); end
            checks++; if (in_ready !== (rdy ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL bp_in_ready k%0d: got %b expected %b", k, in_ready, rdy ? 4'b0010 : 4'b0000); end
            next_cycle();
            if (rdy) b++;
        end
        in_valid = 4'b0000; in_last = 4'b0000; out_ready = 1'b1; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release: got %b expected 0", busy); end
    endtask

    // ch0 6 beats without last, ch1 pending; ptr=2 on entry so ch0 wins first.
    task automatic test_max_beats();
        in_valid = 4'b0011; in_last = 4'b0000; d[0] = 8'hB0; d[1] = 8'hC0; out_ready = 1'b1;
        next_cycle();
        for (int b = 0; b < 4; b++) begin
            d[0] = 8'(8'hB0 + b); #1;
            checks++; if (sel !== 2'd0 || out_data !== 8'(8'hB0 + b)) begin errors++; $display("FAIL mb_ch0 b%0d: got sel=%0d data=%h expected sel=0 data=%h", b, sel, out_data, 8'(8'hB0 + b)); end
            next_cycle();
        end
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mb_forced_release: got %b expected 0", busy); end
        in_last = 4'b0010;
        next_cycle(); #1;
        checks++; if (sel !== 2'd1 || out_data !== 8'hC0) begin errors++; $display("FAIL mb_ch1: got sel=%0d data=%h expected sel=1 data=c0", sel, out_data); end
        next_cycle();
        in_valid = 4'b0001; in_last = 4'b0000; d[0] = 8'hB4;
        next_cycle(); #1;
        checks++; if (sel !== 2'd0 || out_data !== 8'hB4) begin errors++; $display("FAIL mb_ch0_resume5: got sel=%0d data=%h expected sel=0 data=b4", sel, out_data); end
        next_cycle();
        d[0] = 8'hB5; in_last = 4'b0001; #1;
        checks++; if (out_data !== 8'hB5 || out_last !== 1'b1) begin errors++; $display("FAIL mb_ch0_resume6: got data=%h last=%b expected data=b5 last=1", out_data, out_last); end
        next_cycle();
        in_valid = 4'b0000; in_last = 4'b0000; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mb_end_idle: got %b expected 0", busy); end
    endtask

    // Reset on beat 2 of a ch2 packet; afterwards ptr=0 must favour ch0 over ch2.
    task automatic test_reset_mid_packet();
        in_valid = 4'b0100; in_last = 4'b0000; d[2] = 8'hD0; out_ready = 1'b1;
        next_cycle(); #1;
        checks++; if (sel !== 2'd2) begin errors++; $display("FAIL rst_mid_grant: got %0d expected 2", sel); end
        next_cycle();
        d[2] = 8'hD1; rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1; in_valid = 4'b0101; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL rst_mid_in_ready: got %b expected 0000", in_ready); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL rst_mid_sel: got %0d expected 0", sel); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
        next_cycle(); #1;
        checks++; if (sel !== 2'd0 || in_ready !== 4'b0001) begin errors++; $display("FAIL rst_mid_ptr0: got sel=%0d rdy=%b expected sel=0 rdy=0001", sel, in_ready); end
    endtask

    initial begin
        test_reset();
        test_all_four();
        test_wrap();
        test_backpressure();
        test_max_beats();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
